mac_2bit_acc: RTL and testbench
===============================

# mac_2bit_acc

Multiply-accumulate stage built around the 2-bit unsigned multiplier (`multiply_2bit`), which it instantiates combinationally. It accepts a burst of operand pairs over a valid/ready handshake and sums the 4-bit products into a registered accumulator. It presents the final sum on an output valid/ready handshake. It sits directly downstream of the multiplier and is the first sequential stage of the datapath.

## Interface
- `ACC_W`, default 8: accumulator and result width. Must be ≥ 4.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a burst. Sampled only in IDLE.
- `len` input 4: burst length, sampled with `start`. 0 means 16 beats.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: operand pair accepted this cycle when high together with `in_valid`.
- `op1` input 2: unsigned multiplicand.
- `op2` input 2: unsigned multiplier.
- `out_valid` output 1: `acc_out` holds the final burst sum.
- `out_ready` input 1: downstream consumes the result.
- `acc_out` output ACC_W: accumulator register, driven directly.
- `busy` output 1: high in ACC and DONE.
- `overflow` output 1: sticky per burst. Set when any addition carries out of ACC_W bits.

## Operation
- FSM states: IDLE, ACC, DONE. State, counter, accumulator and flags are all registered.
- **IDLE**
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - When `start`=1: load `cnt` = (`len`==0 ? 16 : `len`), clear `acc` and `overflow`, go to ACC.
- **ACC**
  - `in_ready`=1, `busy`=1.
  - Each beat with `in_valid`=1:
    - product p = `op1`*`op2` (0..9), zero-extended to ACC_W+1 bits.
    - sum = `acc` + p. `acc` ← low ACC_W bits of sum.
    - If sum[ACC_W]=1, set `overflow`.
    - `cnt` decrements.
  - When the beat with `cnt`==1 is accepted, go to DONE.
  - While `in_valid`=0, everything holds.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - `acc_out` and `overflow` hold until `out_valid`&&`out_ready`, then go to IDLE.
  - `acc_out` keeps its value in IDLE until the next `start` clears it.
- `start` is ignored in ACC and DONE. A `start` in the same cycle DONE is left is ignored; it must be re-asserted in IDLE.
- Width rule: the maximum burst sum is 16×9 = 144. ACC_W ≥ 8 therefore never overflows.
- Reset (async, any state):
  - state → IDLE, `acc`=0, `cnt`=0, `overflow`=0.
  - Outputs: `in_ready`=0, `out_valid`=0, `busy`=0, `acc_out`=0.
  - A reset mid-burst discards the burst with no partial result.

## Timing
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from any input to them.
- Latency:
  - `start` at edge k → `in_ready`=1 from cycle k+1.
  - Last beat accepted at edge m → `out_valid`=1 from cycle m+1, with `acc_out` already including that beat.
- Throughput: one beat per cycle. A burst of N beats with no stalls takes N+2 cycles from `start` to the result handshake, with `out_ready` held high.
- Multiplier path: combinational from `op1`/`op2` into the adder within one cycle.

## Configuration
- `MAC_SAT_EN`
  - Defined: on carry-out, `acc` ← all ones (2^ACC_W − 1) and stays there for the rest of the burst. `overflow` is set.
  - Undefined: `acc` wraps modulo 2^ACC_W. `overflow` is set.
  - Handshake and timing are identical in both builds.

## Test plan
- **Basic burst:** ACC_W=8, `start` with `len`=3; beats (3,3), (2,1), (1,0) back-to-back → `out_valid` one cycle after the third beat, `acc_out`=11, `overflow`=0.
- **Max burst:** `len`=0, 16 beats of (3,3) → `acc_out`=144 (0x90), `overflow`=0, `out_valid` at cycle 17 after `start`.
- **Overflow:** ACC_W=6, `len`=0, 16×(3,3).
  - Without `MAC_SAT_EN`: `acc_out`=16, `overflow`=1.
  - With `MAC_SAT_EN`: `acc_out`=63, `overflow`=1.
- **Backpressure:**
  - `len`=2, `in_valid` low for 3 cycles between beats (2,3) and (3,2) → `acc_out`=12.
  - `out_ready` held low for 5 cycles → `out_valid` and `acc_out` stable throughout.
  - `start` pulsed during ACC and DONE → ignored.
- **Reset mid-burst:** `len`=4, assert `rst` after 2 beats → all outputs 0 immediately (asynchronously). A new burst with `len`=1, (2,2) → `acc_out`=4.

Source files
------------

// File: rtl/mac_2bit_acc.sv
// Burst multiply-accumulate over a 2x2-bit unsigned multiplier, with valid/ready in and out.
// Optional build macro MAC_SAT_EN: saturate the accumulator on carry-out instead of wrapping.
module multiply_2bit (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  assign p_o = {2'b00, a_i} * {2'b00, b_i};
endmodule

module mac_2bit_acc #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op1,
  input  logic [1:0]       op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q;
  logic [4:0]       cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       prod;
  logic [ACC_W:0]   sum_d;
  logic [ACC_W-1:0] acc_d;

  multiply_2bit u_mul (
    .a_i (op1),
    .b_i (op2),
    .p_o (prod)
  );

  assign sum_d = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, prod};

  // Once saturated, every later add carries out again, so the acc stays pinned.
`ifdef MAC_SAT_EN
  assign acc_d = sum_d[ACC_W] ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
`else
  assign acc_d = sum_d[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACC;
            cnt_q      <= (len == 4'd0) ? 5'd16 : {1'b0, len};
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 5'd1;
            if (sum_d[ACC_W]) ovf_q <= 1'b1;
            if (cnt_q == 5'd1) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac_2bit_acc.sv
// Bench for mac_2bit_acc: an 8-bit and a 6-bit instance share stimulus and are
// checked every cycle against a burst-level sum model plus hand-computed literals.
module tb_mac_2bit_acc;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [1:0] op1, op2;
  logic       out_ready;

  logic       in_ready8, out_valid8, busy8, ovf8;
  logic [7:0] acc8;
  logic       in_ready6, out_valid6, busy6, ovf6;
  logic [5:0] acc6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_2bit_acc #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready8), .op1(op1), .op2(op2), .out_valid(out_valid8),
    .out_ready(out_ready), .acc_out(acc8), .busy(busy8), .overflow(ovf8)
  );

  mac_2bit_acc #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready6), .op1(op1), .op2(op2), .out_valid(out_valid6),
    .out_ready(out_ready), .acc_out(acc6), .busy(busy6), .overflow(ovf6)
  );

  // Model: phase 0 idle, 1 collecting beats, 2 result held; sum is the exact burst total.
  int m_phase = 0;
  int m_left  = 0;
  int m_sum   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_sum = 0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          m_left  = (len == 0) ? 16 : int'(len);
          m_sum   = 0;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          m_sum  = m_sum + int'(op1) * int'(op2);
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
      end else begin
        if (out_ready) m_phase = 0;
      end
    end
  end

  function automatic int exp_acc(int sum, int w);
    int lim = (1 << w);
`ifdef MAC_SAT_EN
    return (sum >= lim) ? lim - 1 : sum;
`else
    return sum % lim;
`endif
  endfunction

  function automatic int exp_ovf(int sum, int w);
    return (sum >= (1 << w)) ? 1 : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready8",  int'(in_ready8),  (m_phase == 1) ? 1 : 0);
    chk("out_valid8", int'(out_valid8), (m_phase == 2) ? 1 : 0);
    chk("busy8",      int'(busy8),      (m_phase != 0) ? 1 : 0);
    chk("acc8",       int'(acc8),       exp_acc(m_sum, 8));
    chk("ovf8",       int'(ovf8),       exp_ovf(m_sum, 8));
    chk("in_ready6",  int'(in_ready6),  (m_phase == 1) ? 1 : 0);
    chk("out_valid6", int'(out_valid6), (m_phase == 2) ? 1 : 0);
    chk("busy6",      int'(busy6),      (m_phase != 0) ? 1 : 0);
    chk("acc6",       int'(acc6),       exp_acc(m_sum, 6));
    chk("ovf6",       int'(ovf6),       exp_ovf(m_sum, 6));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [3:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] a, input logic [1:0] b);
    in_valid = 1'b1; op1 = a; op2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
    op1 = 2'd0; op2 = 2'd0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_acc8",  int'(acc8), 0);
    chk("reset_busy8", int'(busy8), 0);
    rst = 1'b0;
    tick();

    // Basic burst: 9 + 2 + 0 = 11
    start_burst(4'd3);
    chk("basic_in_ready", int'(in_ready8), 1);
    beat(2'd3, 2'd3); beat(2'd2, 2'd1); beat(2'd1, 2'd0);
    chk("basic_out_valid", int'(out_valid8), 1);
    chk("basic_acc",       int'(acc8), 11);
    chk("basic_ovf",       int'(ovf8), 0);
    out_ready = 1'b1;
    tick();
    chk("basic_idle", int'(out_valid8), 0);
    chk("basic_acc_hold", int'(acc8), 11);

    // Max burst: 16 x 9 = 144; result visible at cycle 17 after start
    start_burst(4'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("max_not_early", int'(out_valid8), 0);
      beat(2'd3, 2'd3);
    end
    chk("max_out_valid", int'(out_valid8), 1);
    chk("max_acc8",      int'(acc8), 144);
    chk("max_ovf8",      int'(ovf8), 0);
`ifdef MAC_SAT_EN
    chk("ovf_acc6", int'(acc6), 63);
`else
    chk("ovf_acc6", int'(acc6), 16);
`endif
    chk("ovf_flag6", int'(ovf6), 1);
    tick();
    chk("max_idle", int'(busy8), 0);

    // Backpressure: 6 + 6 = 12 with a 3-cycle input gap and stray starts
    out_ready = 1'b0;
    start_burst(4'd2);
    beat(2'd2, 2'd3);
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    beat(2'd3, 2'd2);
    chk("bp_acc", int'(acc8), 12);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      chk("bp_hold_valid", int'(out_valid8), 1);
      chk("bp_hold_acc",   int'(acc8), 12);
    end
    out_ready = 1'b1; start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    chk("bp_released", int'(out_valid8), 0);
    tick();
    chk("bp_start_ignored", int'(busy8), 0);

    // Async reset mid-burst, then a fresh 1-beat burst: 2*2 = 4
    start_burst(4'd4);
    beat(2'd1, 2'd1); beat(2'd1, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_acc",      int'(acc8), 0);
    chk("rst_busy",     int'(busy8), 0);
    chk("rst_in_ready", int'(in_ready8), 0);
    tick();
    rst = 1'b0;
    tick();
    start_burst(4'd1);
    beat(2'd2, 2'd2);
    chk("post_rst_valid", int'(out_valid8), 1);
    chk("post_rst_acc",   int'(acc8), 4);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
